id_ex_register: RTL

//   ID/EX pipeline register directly downstream of the decode-stage Control unit.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/id_ex_register_pipe_sat_counter.sv | 27 ++
 rtl/id_ex_register.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the pipeline registers.
//   - Default datapath / register-address widths
//   - ALUOp encodings and base opcode constants
//   - ctrl_t: the 8-bit decoded control bundle produced by the Control unit
package cpu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // ALUOp encodings; 01 and 11 are reserved and carried through untouched.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // RV32 base opcodes recognised by the Control unit.
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // All-zero control bundle: a bubble that touches no architectural state.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_register_pipe_sat_counter.sv
// pipe_sat_counter: saturating up-counter for pipeline performance statistics.
//   clk_i  in   clock, rising edge
//   rst_i  in   asynchronous active-low reset, clears the count
//   inc_i  in   count one event on this edge
//   cnt_o  out  current count; sticks at all-ones instead of wrapping
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register downstream of the Control unit.
// Captures control, register data, immediate, funct and register addresses
// and presents them to EX one cycle later, with flush / stall / no-op control.
//   clk_i, rst_i              clock and asynchronous active-low reset
//   stall_i, flush_i, noop_i  hold / bubble (branch) / bubble (load-use);
//                             priority flush > stall > noop > capture
//   <ctrl>_i                  RegWrite, MemtoReg, MemRead, MemWrite, Branch,
//                             ALUSrc, ALUOp from Control
//   PC/RS1data/RS2data/imm_i  XLEN-bit data; funct_i {funct7,funct3}
//   RS1addr/RS2addr/RDaddr_i  register addresses
//   <same>_o                  registered copies; valid_o marks a real instruction
//   bubble_cnt_o, stall_cnt_o saturating statistics, present only when
//                             ID_EX_PERF_EN is defined
module id_ex_register
  import cpu_pkg::*;
#(
`ifdef ID_EX_PERF_EN
  parameter int CNT_W  = 16,
`endif
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              noop_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              Branch_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [XLEN-1:0]   PC_i,
  input  logic [XLEN-1:0]   RS1data_i,
  input  logic [XLEN-1:0]   RS2data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [9:0]        funct_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              Branch_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [XLEN-1:0]   PC_o,
  output logic [XLEN-1:0]   RS1data_o,
  output logic [XLEN-1:0]   RS2data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [9:0]        funct_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
`ifdef ID_EX_PERF_EN
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
`endif
  output logic              valid_o
);

  ctrl_t             ctrl_in;
  ctrl_t             ctrl_d,  ctrl_q;
  logic [XLEN-1:0]   pc_d,    pc_q;
  logic [XLEN-1:0]   rs1d_d,  rs1d_q;
  logic [XLEN-1:0]   rs2d_d,  rs2d_q;
  logic [XLEN-1:0]   imm_d,   imm_q;
  logic [9:0]        funct_d, funct_q;
  logic [REG_AW-1:0] rs1a_d,  rs1a_q;
  logic [REG_AW-1:0] rs2a_d,  rs2a_q;
  logic [REG_AW-1:0] rd_d,    rd_q;
  logic              valid_d, valid_q;

  always_comb begin
    ctrl_in = '{reg_write:  RegWrite_i,
                mem_to_reg: MemtoReg_i,
                mem_read:   MemRead_i,
                mem_write:  MemWrite_i,
                branch:     Branch_i,
                alu_src:    ALUSrc_i,
                alu_op:     ALUOp_i};
    // A write to x0 is dropped here so EX/MEM forwarding can never match x0.
    if (RDaddr_i == '0) ctrl_in.reg_write = 1'b0;
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    funct_d = funct_q;
    rs1a_d  = rs1a_q;
    rs2a_d  = rs2a_q;
    rd_d    = rd_q;
    valid_d = valid_q;

    if (flush_i) begin
      ctrl_d  = CTRL_BUBBLE;
      pc_d    = '0;
      rs1d_d  = '0;
      rs2d_d  = '0;
      imm_d   = '0;
      funct_d = '0;
      rs1a_d  = '0;
      rs2a_d  = '0;
      rd_d    = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      // Data and source addresses flow through for both capture and no-op;
      // a load-use bubble only kills control, destination and valid.
      pc_d    = PC_i;
      rs1d_d  = RS1data_i;
      rs2d_d  = RS2data_i;
      imm_d   = imm_i;
      funct_d = funct_i;
      rs1a_d  = RS1addr_i;
      rs2a_d  = RS2addr_i;
      if (noop_i) begin
        ctrl_d  = CTRL_BUBBLE;
        rd_d    = '0;
        valid_d = 1'b0;
      end else begin
        ctrl_d  = ctrl_in;
        rd_d    = RDaddr_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q  <= CTRL_BUBBLE;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      funct_q <= '0;
      rs1a_q  <= '0;
      rs2a_q  <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      funct_q <= funct_d;
      rs1a_q  <= rs1a_d;
      rs2a_q  <= rs2a_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

  assign RegWrite_o = ctrl_q.reg_write;
  assign MemtoReg_o = ctrl_q.mem_to_reg;
  assign MemRead_o  = ctrl_q.mem_read;
  assign MemWrite_o = ctrl_q.mem_write;
  assign Branch_o   = ctrl_q.branch;
  assign ALUSrc_o   = ctrl_q.alu_src;
  assign ALUOp_o    = ctrl_q.alu_op;
  assign PC_o       = pc_q;
  assign RS1data_o  = rs1d_q;
  assign RS2data_o  = rs2d_q;
  assign imm_o      = imm_q;
  assign funct_o    = funct_q;
  assign RS1addr_o  = rs1a_q;
  assign RS2addr_o  = rs2a_q;
  assign RDaddr_o   = rd_q;
  assign valid_o    = valid_q;

`ifdef ID_EX_PERF_EN
  // A noop during a stall is not honoured, so it does not count as a bubble.
  logic bubble_inc;
  logic stall_inc;

  assign bubble_inc = flush_i | (noop_i & ~stall_i);
  assign stall_inc  = stall_i & ~flush_i;

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_inc),
    .cnt_o (bubble_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );
`endif

endmodule
